// File: rtl/typed_const_bank.sv
// Typed constant bank: a small register file whose entries carry a value
// cast to one of seven integer types plus the stored type code. Contents
// are initialised after reset and can be frozen with a sticky lock.
module typed_const_bank #(
  parameter int NUM_ENTRIES = 8,
  parameter int DATA_W      = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  logic [$clog2(NUM_ENTRIES)-1:0]     wr_addr,
  input  logic [2:0]                         wr_type,
  input  logic [DATA_W-1:0]                  wr_data,
  output logic                               wr_err,
  input  logic                               rd_valid,
  input  logic [$clog2(NUM_ENTRIES)-1:0]     rd_addr,
  output logic [DATA_W-1:0]                  rd_data,
  output logic [2:0]                         rd_type,
  output logic                               rd_data_valid,
  output logic                               rd_err,
  input  logic                               lock,
  output logic                               init_done
);

  localparam int ADDR_W = $clog2(NUM_ENTRIES);

  localparam logic [2:0]        TYPE_BIT      = 3'd0;
  localparam logic [2:0]        TYPE_BYTE     = 3'd1;
  localparam logic [2:0]        TYPE_SHORTINT = 3'd2;
  localparam logic [2:0]        TYPE_INT      = 3'd3;
  localparam logic [2:0]        TYPE_LONGINT  = 3'd4;
  localparam logic [2:0]        TYPE_TIME     = 3'd5;
  localparam logic [2:0]        TYPE_INTEGER  = 3'd6;
  localparam logic [2:0]        TYPE_RSVD     = 3'd7;
  localparam logic [ADDR_W:0]   NUM_LIMIT     = (ADDR_W+1)'(NUM_ENTRIES);
  localparam logic [ADDR_W-1:0] LAST_SLOT     = ADDR_W'(NUM_ENTRIES - 1);

  typedef enum logic [1:0] {INIT, IDLE, LOCKED} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   init_cnt;

  logic [DATA_W-1:0]   mem_data [NUM_ENTRIES];
  logic [2:0]          mem_type [NUM_ENTRIES];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [2:0]          mem_wtype;

  logic                wr_accept, wr_in_range, wr_bad;
  logic                rd_take, rd_in_range;

  // Truncate the raw value to the target type and extend back to DATA_W.
  function automatic logic [DATA_W-1:0] cast_value(input logic [2:0] t,
                                                   input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = '0;
    case (t)
      TYPE_BIT:      r = DATA_W'(d[0]);
      TYPE_BYTE:     r = DATA_W'($signed(d[7:0]));
      TYPE_SHORTINT: r = DATA_W'($signed(d[15:0]));
      TYPE_INT:      r = DATA_W'($signed(d[31:0]));
      TYPE_INTEGER:  r = DATA_W'($signed(d[31:0]));
      TYPE_LONGINT:  r = DATA_W'($signed(d[63:0]));
      TYPE_TIME:     r = DATA_W'(d[63:0]);
      default:       r = '0;
    endcase
    return r;
  endfunction

  // Write acceptance, error classification and the single memory write port
  // shared between the INIT sweep and user writes.
  always_comb begin
    wr_ready    = (state != INIT);
    init_done   = (state != INIT);
    wr_accept   = wr_valid && wr_ready;
    wr_in_range = ({1'b0, wr_addr} < NUM_LIMIT);
    wr_bad      = wr_accept &&
                  ((state == LOCKED) || !wr_in_range || (wr_type == TYPE_RSVD));
    rd_take     = rd_valid && (state != INIT);
    rd_in_range = ({1'b0, rd_addr} < NUM_LIMIT);

    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wtype = TYPE_INT;
    if (state == INIT) begin
      mem_we   = 1'b1;
      mem_addr = init_cnt;
    end else if ((state == IDLE) && wr_accept && !wr_bad) begin
      mem_we    = 1'b1;
      mem_addr  = wr_addr;
      mem_wdata = cast_value(wr_type, wr_data);
      mem_wtype = wr_type;
    end
  end

  // Next-state logic; lock is only honoured once the bank is initialised.
  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (init_cnt == LAST_SLOT) state_next = IDLE;
      IDLE:    if (lock) state_next = LOCKED;
      LOCKED:  state_next = LOCKED;
      default: state_next = INIT;
    endcase
  end

  // State register and INIT slot counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) init_cnt <= init_cnt + ADDR_W'(1);
    end
  end

  // Bank storage; contents are defined by the INIT sweep, not by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_data[mem_addr] <= mem_wdata;
      mem_type[mem_addr] <= mem_wtype;
    end
  end

  // One-cycle error pulse for rejected writes.
  always_ff @(posedge clk) begin
    if (rst) wr_err <= 1'b0;
    else     wr_err <= wr_bad;
  end

  // Registered read port; reads sample pre-write contents of the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_valid <= 1'b0;
      rd_err        <= 1'b0;
      rd_data       <= '0;
      rd_type       <= '0;
    end else begin
      rd_data_valid <= rd_take;
      rd_err        <= rd_take && !rd_in_range;
      if (rd_take) begin
        if (rd_in_range) begin
          rd_data <= mem_data[rd_addr];
          rd_type <= mem_type[rd_addr];
        end else begin
          rd_data <= '0;
          rd_type <= '0;
        end
      end
    end
  end

endmodule
